// File: rtl/timer_multi.sv
// Multi-channel free-running timer: per-channel enable, clear, sample, wrap value and one-shot mode.
// Optional shared prescaler when TIMER_PRESCALE_EN is defined (adds the presc_div port).
module timer_multi #(
   parameter int NUM_CH  = 4,
   parameter int COUNT_W = 64,
   parameter int PRESC_W = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CH-1:0]           en,
   input  logic [NUM_CH-1:0]           clr,
   input  logic [NUM_CH-1:0]           sample,
   input  logic [NUM_CH-1:0]           oneshot,
   input  logic [NUM_CH*COUNT_W-1:0]   wrap_val,
`ifdef TIMER_PRESCALE_EN
   input  logic [PRESC_W-1:0]          presc_div,
`endif
   output logic [NUM_CH*COUNT_W-1:0]   count_o,
   output logic [NUM_CH*COUNT_W-1:0]   sample_o,
   output logic [NUM_CH-1:0]           sample_vld,
   output logic [NUM_CH-1:0]           wrap_evt,
   output logic [NUM_CH-1:0]           done
);

   logic tick;

`ifdef TIMER_PRESCALE_EN
   logic [PRESC_W-1:0] presc;

   // A divider lowered below the running value wraps to 0 without producing a tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (presc >= presc_div) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   assign tick = (presc == presc_div);
`else
   // No prescaler: every cycle is a tick (PRESC_W is always >= 1).
   assign tick = (PRESC_W > 0);
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [COUNT_W-1:0] cnt;
      logic [COUNT_W-1:0] samp;
      logic [COUNT_W-1:0] wv;
      logic               svld;
      logic               wevt;
      logic               dn;
      logic               adv;

      assign wv  = wrap_val[i*COUNT_W +: COUNT_W];
      assign adv = tick & en[i] & ~dn;

      // clr beats the terminal check, which beats the increment; sample sees the pre-update count.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt  <= '0;
            samp <= '0;
            svld <= 1'b0;
            wevt <= 1'b0;
            dn   <= 1'b0;
         end else begin
            svld <= sample[i];
            wevt <= 1'b0;
            if (sample[i]) begin
               samp <= cnt;
            end
            if (clr[i]) begin
               cnt <= '0;
               dn  <= 1'b0;
            end else if (adv && (cnt >= wv)) begin
               wevt <= 1'b1;
               if (oneshot[i]) begin
                  dn <= 1'b1;
               end else begin
                  cnt <= '0;
               end
            end else if (adv) begin
               cnt <= cnt + COUNT_W'(1);
            end
         end
      end

      assign count_o[i*COUNT_W +: COUNT_W]  = cnt;
      assign sample_o[i*COUNT_W +: COUNT_W] = samp;
      assign sample_vld[i]                  = svld;
      assign wrap_evt[i]                    = wevt;
      assign done[i]                        = dn;
   end

endmodule

// File: tb/tb_timer_multi.sv
// Bench for timer_multi: hand-derived vector table on channel 3, directed corner sequences,
// and randomized traffic checked every cycle against a per-channel arithmetic model.
module tb_timer_multi;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int PW  = 8;

   logic              clk;
   logic              rst;
   logic [NCH-1:0]    en, clr, sample, oneshot;
   logic [NCH*CW-1:0] wrap_val;
   logic [NCH*CW-1:0] count_o, sample_o;
   logic [NCH-1:0]    sample_vld, wrap_evt, done;
`ifdef TIMER_PRESCALE_EN
   logic [PW-1:0]     presc_div;
`endif

   timer_multi #(.NUM_CH(NCH), .COUNT_W(CW), .PRESC_W(PW)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .sample(sample), .oneshot(oneshot),
      .wrap_val(wrap_val),
`ifdef TIMER_PRESCALE_EN
      .presc_div(presc_div),
`endif
      .count_o(count_o), .sample_o(sample_o), .sample_vld(sample_vld),
      .wrap_evt(wrap_evt), .done(done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog ch0: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   int vectors = 0;
   int errors  = 0;

   // reference model state
   int m_cnt[NCH], m_samp[NCH];
   bit m_done[NCH], m_wrap[NCH], m_svld[NCH];
   int m_presc;

   typedef struct {
      logic       en, clr, smp, os;
      logic [7:0] cnt;
      logic       wrap, dn, svld;
      logic [7:0] samp;
   } tv_t;
   tv_t tbl[12];

   task automatic chk(input string nm, input int ch, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ch%0d: actual %0h required %0h", nm, ch, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_cnt[i] = 0; m_samp[i] = 0; m_done[i] = 0; m_wrap[i] = 0; m_svld[i] = 0;
      end
      m_presc = 0;
   endtask

   // Advance the model by one clock using the current inputs, then clock the DUT and compare.
   task automatic step();
      bit tick;
      int wv;
      tick = 1'b1;
`ifdef TIMER_PRESCALE_EN
      tick    = (m_presc == int'(presc_div));
      m_presc = (m_presc >= int'(presc_div)) ? 0 : m_presc + 1;
`endif
      for (int i = 0; i < NCH; i++) begin
         wv        = int'(wrap_val[i*CW +: CW]);
         m_svld[i] = sample[i];
         if (sample[i]) m_samp[i] = m_cnt[i];
         m_wrap[i] = 1'b0;
         if (clr[i]) begin
            m_cnt[i]  = 0;
            m_done[i] = 1'b0;
         end else if (tick && en[i] && !m_done[i]) begin
            if (m_cnt[i] >= wv) begin
               m_wrap[i] = 1'b1;
               if (oneshot[i]) m_done[i] = 1'b1;
               else            m_cnt[i]  = 0;
            end else begin
               m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
         chk("count_o",    i, count_o[i*CW +: CW],  m_cnt[i]);
         chk("sample_o",   i, sample_o[i*CW +: CW], m_samp[i]);
         chk("sample_vld", i, sample_vld[i],        m_svld[i]);
         chk("wrap_evt",   i, wrap_evt[i],          m_wrap[i]);
         chk("done",       i, done[i],              m_done[i]);
      end
   endtask

   task automatic wait_cnt(input int ch, input int val, input int lim);
      int n;
      n = 0;
      while ((int'(count_o[ch*CW +: CW]) != val) && (n < lim)) begin
         step();
         n++;
      end
      chk("wait_count", ch, count_o[ch*CW +: CW], val);
   endtask

   initial begin
      int p0, p1, p2, p3, first0, k1, k2;

      // channel 3, wrap_val=2: {en,clr,smp,os, cnt,wrap,done,svld,samp}
      tbl[0]  = '{1, 0, 0, 0, 8'd1, 0, 0, 0, 8'd0};
      tbl[1]  = '{1, 0, 0, 0, 8'd2, 0, 0, 0, 8'd0};
      tbl[2]  = '{1, 0, 0, 0, 8'd0, 1, 0, 0, 8'd0};
      tbl[3]  = '{0, 0, 0, 0, 8'd0, 0, 0, 0, 8'd0};
      tbl[4]  = '{1, 0, 1, 0, 8'd1, 0, 0, 1, 8'd0};
      tbl[5]  = '{1, 0, 0, 1, 8'd2, 0, 0, 0, 8'd0};
      tbl[6]  = '{1, 0, 0, 1, 8'd2, 1, 1, 0, 8'd0};
      tbl[7]  = '{1, 0, 0, 1, 8'd2, 0, 1, 0, 8'd0};
      tbl[8]  = '{1, 0, 1, 0, 8'd2, 0, 1, 1, 8'd2};
      tbl[9]  = '{1, 1, 0, 0, 8'd0, 0, 0, 0, 8'd2};
      tbl[10] = '{1, 0, 0, 0, 8'd1, 0, 0, 0, 8'd2};
      tbl[11] = '{1, 1, 1, 0, 8'd0, 0, 0, 1, 8'd1};

      rst = 1'b1; en = '0; clr = '0; sample = '0; oneshot = '0; wrap_val = '0;
`ifdef TIMER_PRESCALE_EN
      presc_div = '0;
`endif
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         chk("reset_count",  i, count_o[i*CW +: CW],  0);
         chk("reset_sample", i, sample_o[i*CW +: CW], 0);
         chk("reset_flags",  i, {sample_vld[i], wrap_evt[i], done[i]}, 0);
      end

      // table-driven vectors on channel 3
      wrap_val[3*CW +: CW] = 8'd2;
      for (int r = 0; r < 12; r++) begin
         en[3] = tbl[r].en; clr[3] = tbl[r].clr; sample[3] = tbl[r].smp; oneshot[3] = tbl[r].os;
         step();
         chk("tbl_count", 3, count_o[3*CW +: CW],  tbl[r].cnt);
         chk("tbl_wrap",  3, wrap_evt[3],          tbl[r].wrap);
         chk("tbl_done",  3, done[3],              tbl[r].dn);
         chk("tbl_svld",  3, sample_vld[3],        tbl[r].svld);
         chk("tbl_samp",  3, sample_o[3*CW +: CW], tbl[r].samp);
      end

      // 400-cycle run: periodic 150, one-shot 10, full-range 255, wrap_val 0
      en = '0; sample = '0; clr = '1; oneshot = 4'b0010;
      wrap_val = {8'd0, 8'd255, 8'd10, 8'd150};
      step();
      clr = '0; en = '1;
      p0 = 0; p1 = 0; p2 = 0; p3 = 0; first0 = 0;
      for (int k = 1; k <= 400; k++) begin
         step();
         if (wrap_evt[0]) begin p0++; if (first0 == 0) first0 = k; end
         if (wrap_evt[1]) p1++;
         if (wrap_evt[2]) p2++;
         if (wrap_evt[3]) p3++;
      end
      chk("first_wrap_cycle", 0, first0, 151);
      chk("wrap_pulses",      0, p0, 2);
      chk("oneshot_pulses",   1, p1, 1);
      chk("oneshot_hold",     1, count_o[1*CW +: CW], 10);
      chk("oneshot_done",     1, done[1], 1);
      chk("full_range_pulses", 2, p2, 1);
      chk("zero_wrap_pulses", 3, p3, 400);

      // one-shot restart via clr
      clr = 4'b0010;
      step();
      chk("restart_count", 1, count_o[1*CW +: CW], 0);
      chk("restart_done",  1, done[1], 0);
      clr = '0;
      step();
      chk("restart_run", 1, count_o[1*CW +: CW], 1);

      // sampling on channel 0
      wrap_val[2*CW +: CW] = 8'd200;
      wait_cnt(0, 100, 200);
      sample[0] = 1'b1;
      step();
      sample[0] = 1'b0;
      chk("sample_100", 0, sample_o[0*CW +: CW], 100);
      chk("sample_vld", 0, sample_vld[0], 1);
      step();
      chk("sample_vld_drop", 0, sample_vld[0], 0);
      wait_cnt(0, 42, 200);
      sample[0] = 1'b1; clr[0] = 1'b1;
      step();
      sample[0] = 1'b0; clr[0] = 1'b0;
      chk("sample_clr_value", 0, sample_o[0*CW +: CW], 42);
      chk("sample_clr_count", 0, count_o[0*CW +: CW], 0);

      // lowering wrap_val below the live count forces a wrap
      wait_cnt(2, 80, 300);
      wrap_val[2*CW +: CW] = 8'd50;
      step();
      chk("lowered_wrap_count", 2, count_o[2*CW +: CW], 0);
      chk("lowered_wrap_evt",   2, wrap_evt[2], 1);

`ifdef TIMER_PRESCALE_EN
      // prescaler divide-by-4, wrap_val 4 -> one wrap every 20 cycles
      presc_div = 8'd3; en = '0; clr = '1; oneshot = '0;
      wrap_val[0*CW +: CW] = 8'd4;
      step();
      clr = '0; en = 4'b0001;
      k1 = 0; k2 = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (wrap_evt[0]) begin
            if (k1 == 0) k1 = k;
            else if (k2 == 0) k2 = k;
         end
      end
      chk("presc_spacing", 0, k2 - k1, 20);
      presc_div = '0;
`else
      k1 = 0; k2 = 0;
`endif

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NCH; i++) begin
            en[i]     = ($urandom_range(0, 9) != 0);
            clr[i]    = ($urandom_range(0, 39) == 0);
            sample[i] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) oneshot[i] = ~oneshot[i];
            if ($urandom_range(0, 29) == 0)
               wrap_val[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 30));
         end
`ifdef TIMER_PRESCALE_EN
         if ($urandom_range(0, 99) == 0) presc_div = PW'($urandom_range(0, 5));
`endif
         step();
      end

      // asynchronous reset mid-count
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      for (int i = 0; i < NCH; i++) begin
         chk("async_rst_count",  i, count_o[i*CW +: CW],  0);
         chk("async_rst_sample", i, sample_o[i*CW +: CW], 0);
         chk("async_rst_flags",  i, {sample_vld[i], wrap_evt[i], done[i]}, 0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 50; k++) begin
         for (int i = 0; i < NCH; i++) sample[i] = ($urandom_range(0, 3) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised successor to the single 64-bit timer: NUM_CH independent free-running counters, each COUNT_W bits wide, with its own enable, clear, sample and wrap value.
- Adds a per-channel one-shot mode, a wrap-event pulse and a sample-valid strobe.
- Sits beside the CPU peripheral registers; the register wrapper drives controls and reads sampled counts.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- COUNT_W, 64, counter width per channel (8..64).
- PRESC_W, 16, prescaler divider width (used only with TIMER_PRESCALE_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- en  in  NUM_CH  per-channel count enable, level.
- clr  in  NUM_CH  per-channel synchronous clear, single-cycle pulse or level.
- sample  in  NUM_CH  per-channel sample request, pulse.
- oneshot  in  NUM_CH  mode: 1 = stop at wrap, 0 = periodic.
- wrap_val  in  NUM_CH*COUNT_W  terminal count per channel; channel i uses bits [i*COUNT_W +: COUNT_W].
- count_o  out  NUM_CH*COUNT_W  live counter values.
- sample_o  out  NUM_CH*COUNT_W  latched sample values.
- sample_vld  out  NUM_CH  one-cycle strobe when sample_o[i] is updated.
- wrap_evt  out  NUM_CH  one-cycle pulse when channel i reaches its terminal count.
- done  out  NUM_CH  sticky; set when a one-shot channel terminates.
- presc_div  in  PRESC_W  prescaler divide-minus-one (present only with TIMER_PRESCALE_EN).

Behaviour:
- Reset: count_o, sample_o, sample_vld, wrap_evt and done are all 0; the prescaler is 0. Reset takes effect immediately and mid-operation.
- tick is 1 every cycle without the prescaler. Channel i advances only when tick & en[i] & !done[i].
- Priority per channel, per cycle: clr > terminal > increment.
  - clr[i]=1: count <= 0 and done <= 0. No wrap_evt that cycle, even if terminal.
  - Terminal condition: advance & (count >= wrap_val). Use >= so that lowering wrap_val below count forces a wrap on the next advance.
    - Periodic: count <= 0 and wrap_evt=1 on the following cycle.
    - One-shot: count holds and done <= 1, with wrap_evt=1 once.
  - Otherwise, on advance: count <= count+1, modulo 2^COUNT_W; overflow is unreachable while wrap_val < 2^COUNT_W-1.
- wrap_val=0 in periodic mode: count stays 0 and wrap_evt pulses on every tick while enabled.
- en low holds count; done is unaffected. A done one-shot channel restarts only after clr.
- oneshot changed mid-run takes effect at the next terminal check. Clearing oneshot while done=1 does not clear done.
- Sample: sample[i] in cycle N sets sample_o[i] to count_o[i] as it was in cycle N (pre-update value) and pulses sample_vld[i] for 1 cycle, both visible in cycle N+1.
  - sample together with clr or wrap captures the pre-clear/pre-wrap value.
  - Back-to-back samples update every cycle.
- wrap_evt and sample_vld are registered and high for exactly one cycle per event.
- Channels are fully independent; no cross-channel interaction except the shared prescaler.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined: the presc_div port exists and a shared PRESC_W-bit prescaler counts 0..presc_div. tick=1 in the cycle the prescaler equals presc_div, and the prescaler then returns to 0.
  - presc_div=0 gives tick every cycle.
  - If presc_div is changed below the current prescaler value, the prescaler wraps to 0 on the next cycle without a tick.
  - clr and sample remain cycle-accurate, i.e. not gated by tick.
- Undefined: no presc_div port, no prescaler logic, tick is constant 1.

Test Plan:
- Reset, then en[0]=1, oneshot=0, wrap_val[0]=150 for 400 cycles -> count_o[0] cycles 0..150; wrap_evt[0] pulses every 151 cycles, first pulse 151 cycles after en rises.
- Ch1 oneshot=1, wrap_val=10, en=1 -> count_o[1] stops at 10, done[1]=1, exactly one wrap_evt[1]; pulse clr[1] -> count 0, done 0, counting resumes.
- Sample ch0 at count 100 -> next cycle sample_o[0]=100, sample_vld[0]=1 for 1 cycle. Sample and clr in the same cycle at count 42 -> sample_o=42, count_o=0.
- Ch2 counting at 80, wrap_val changed to 50 -> next advance wraps to 0 with wrap_evt[2]. wrap_val=0 periodic -> wrap_evt every cycle, count stays 0.
- Assert rst asynchronously mid-count on all channels -> all outputs 0 immediately. With NUM_CH=4, COUNT_W=8, wrap_val=255 -> counts 0..255 with no overflow glitch.
- TIMER_PRESCALE_EN, presc_div=3, wrap_val=4 -> count advances every 4 cycles, wrap_evt every 20 cycles. presc_div=0 -> identical to the non-prescaled result.
